// File: rtl/tauri_geo_pkg.sv
// Shared geometry types and constants for the clipper-to-rasteriser path.
package tauri_geo_pkg;

    localparam int unsigned VERTS_PER_TRI = 3;
    localparam int unsigned MAX_CLIP_TRIS = 2;
    localparam int unsigned VERTEX_W      = 32;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT0 = 2'd1,
        EMIT1 = 2'd2
    } state_t;

    // Packed struct members fill from the MSB, so x is declared last to sit at the LSBs.
    typedef struct packed {
        logic [VERTEX_W-1:0] w;
        logic [VERTEX_W-1:0] z;
        logic [VERTEX_W-1:0] y;
        logic [VERTEX_W-1:0] x;
    } vertex_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_d, count_q;

    // Next count: clear, else increment unless already all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !(&count_q)) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/clip_tri_sequencer.sv
// Captures a clip result (up to two triangles) and issues the triangles one at a time
// to the rasteriser over valid/ready, keeping culled/illegal/overflow statistics.
module clip_tri_sequencer
    import tauri_geo_pkg::*;
#(
    parameter int unsigned VERTEX_WIDTH = 32,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        done_i,
    input  logic [1:0]                  num_triangles_i,
    input  logic [24*VERTEX_WIDTH-1:0]  clip_v_i,
    output logic                        ready_o,
    output logic                        tri_valid_o,
    input  logic                        tri_ready_i,
    output logic [12*VERTEX_WIDTH-1:0]  tri_v_o,
    output logic                        tri_last_o,
    input  logic                        clear_stats_i,
    output logic [CNT_WIDTH-1:0]        tri_count_o,
    output logic [CNT_WIDTH-1:0]        cull_count_o,
    output logic [CNT_WIDTH-1:0]        err_count_o
);

    localparam int unsigned TriW  = VERTS_PER_TRI * 4 * VERTEX_WIDTH;
    localparam int unsigned ClipW = MAX_CLIP_TRIS * TriW;

    state_t             state_d, state_q;
    logic               two_d, two_q;
    logic [ClipW-1:0]   buf_d, buf_q;
    logic               cull_inc, err_inc, tri_inc;

    // Next-state, capture and statistics-event decode.
    always_comb begin
        state_d  = state_q;
        two_d    = two_q;
        buf_d    = buf_q;
        cull_inc = 1'b0;
        err_inc  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (done_i) begin
                    unique case (num_triangles_i)
                        2'd0: cull_inc = 1'b1;
                        2'd3: err_inc  = 1'b1;
                        default: begin
                            buf_d   = clip_v_i;
                            two_d   = (num_triangles_i == 2'd2);
                            state_d = EMIT0;
                        end
                    endcase
                end
            end
            EMIT0: begin
                // A result arriving while busy is dropped and counted as overflow.
                err_inc = done_i;
                if (tri_ready_i) begin
                    state_d = two_q ? EMIT1 : IDLE;
                end
            end
            EMIT1: begin
                err_inc = done_i;
                if (tri_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and capture buffer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            two_q   <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            two_q   <= two_d;
            buf_q   <= buf_d;
        end
    end

    // Outputs decode straight from registered state, so valid/data/last stay stable under stall.
    always_comb begin
        ready_o     = (state_q == IDLE);
        tri_valid_o = (state_q == EMIT0) || (state_q == EMIT1);
        tri_last_o  = (state_q == EMIT1) || ((state_q == EMIT0) && !two_q);
        tri_v_o     = (state_q == EMIT1) ? buf_q[TriW +: TriW] : buf_q[0 +: TriW];
        tri_inc     = tri_valid_o && tri_ready_i;
    end

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_tri_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (tri_inc),
        .clr_i  (clear_stats_i),
        .count_o(tri_count_o)
    );

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_cull_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (cull_inc),
        .clr_i  (clear_stats_i),
        .count_o(cull_count_o)
    );

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_err_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (err_inc),
        .clr_i  (clear_stats_i),
        .count_o(err_count_o)
    );

endmodule

// File: tb/tb_clip_tri_sequencer.sv
// Self-checking bench: directed steps plus random traffic against a queue-based model.
module tb_clip_tri_sequencer;
    import tauri_geo_pkg::*;

    localparam int VW     = 32;
    localparam int CW     = 16;
    localparam int TW     = 12 * VW;
    localparam int CNTMAX = 65535;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              done;
    logic [1:0]        num;
    logic [24*VW-1:0]  clip_v;
    logic              ready;
    logic              tvalid;
    logic              tready;
    logic [TW-1:0]     tv;
    logic              tlast;
    logic              clr;
    logic [CW-1:0]     tri_cnt, cull_cnt, err_cnt;

    clip_tri_sequencer #(
        .VERTEX_WIDTH(VW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .done_i         (done),
        .num_triangles_i(num),
        .clip_v_i       (clip_v),
        .ready_o        (ready),
        .tri_valid_o    (tvalid),
        .tri_ready_i    (tready),
        .tri_v_o        (tv),
        .tri_last_o     (tlast),
        .clear_stats_i  (clr),
        .tri_count_o    (tri_cnt),
        .cull_count_o   (cull_cnt),
        .err_count_o    (err_cnt)
    );

    always #5 clk = ~clk;

    // Model: a queue of triangles still owed to the rasteriser, plus plain integer counts.
    typedef struct {
        logic [TW-1:0] v;
        logic          last;
    } tri_t;

    tri_t q[$];
    int   m_tri, m_cull, m_err;
    int   total = 0;
    int   bad   = 0;

    function automatic int sat(input int x);
        return (x > CNTMAX) ? CNTMAX : x;
    endfunction

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one clock's worth of the behavioural rules to the model using current inputs.
    task automatic model_step();
        bit   idle;
        tri_t t;
        idle = (q.size() == 0);
        if (!idle && tready) begin
            void'(q.pop_front());
            m_tri = sat(m_tri + 1);
        end
        if (done) begin
            if (!idle) m_err = sat(m_err + 1);
            else if (num == 2'd0) m_cull = sat(m_cull + 1);
            else if (num == 2'd3) m_err = sat(m_err + 1);
            else begin
                t.v    = clip_v[0 +: TW];
                t.last = (num == 2'd1);
                q.push_back(t);
                if (num == 2'd2) begin
                    t.v    = clip_v[TW +: TW];
                    t.last = 1'b1;
                    q.push_back(t);
                end
            end
        end
        if (clr) begin
            m_tri  = 0;
            m_cull = 0;
            m_err  = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ready"}, TW'(ready), TW'(q.size() == 0));
        chk({tag, ".valid"}, TW'(tvalid), TW'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, ".data"}, tv, q[0].v);
            chk({tag, ".last"}, TW'(tlast), TW'(q[0].last));
        end
        chk({tag, ".tri_cnt"}, TW'(tri_cnt), TW'(m_tri));
        chk({tag, ".cull_cnt"}, TW'(cull_cnt), TW'(m_cull));
        chk({tag, ".err_cnt"}, TW'(err_cnt), TW'(m_err));
    endtask

    task automatic drive(input logic d, input logic [1:0] n, input logic r, input logic c);
        done   = d;
        num    = n;
        tready = r;
        clr    = c;
    endtask

    task automatic rand_data();
        for (int i = 0; i < 24; i++) clip_v[i*VW +: VW] = $urandom();
    endtask

    // Vertex k component c = 0x11 + 4k + c, with v2.w pinned to 0x2C.
    task automatic directed_data(input logic [7:0] base);
        vertex_t vx;
        for (int k = 0; k < 6; k++) begin
            vx.x = 32'(base) + 32'(4 * k);
            vx.y = vx.x + 32'd1;
            vx.z = vx.x + 32'd2;
            vx.w = vx.x + 32'd3;
            if (k == 2 && base == 8'h11) vx.w = 32'h2C;
            clip_v[k*4*VW +: 4*VW] = vx;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        clip_v = '0;
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        q.delete();
        m_tri  = 0;
        m_cull = 0;
        m_err  = 0;
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        chk("reset.tri_v", tv, '0);
        chk("reset.last", TW'(tlast), '0);
        rst_n = 1'b1;
        tick();
        check_all("idle");

        // Single triangle, rasteriser always ready.
        directed_data(8'h11);
        drive(1'b1, 2'd1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        check_all("one.emit");
        chk("one.v0x", TW'(tv[31:0]), TW'(32'h11));
        chk("one.v2w", TW'(tv[TW-1 -: 32]), TW'(32'h2C));
        tick();
        check_all("one.after");

        // Two triangles with a 5-cycle stall on the first.
        directed_data(8'h40);
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_all("two.stall");
            if (i < 4) tick();
        end
        tready = 1'b1;
        tick();
        check_all("two.second");
        tick();
        check_all("two.done");

        // Culled and illegal results.
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        tick();
        check_all("cull");
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        check_all("illegal");
        tick();
        check_all("illegal.idle");

        // Overflow: second result during EMIT0 must be dropped.
        directed_data(8'h80);
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        tick();
        directed_data(8'hC0);
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        check_all("ovf.hold");
        tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("ovf.drain");
        end

        // Asynchronous reset while the second triangle is pending.
        rand_data();
        drive(1'b1, 2'd2, 1'b1, 1'b0);
        tick();
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        tick();
        tready = 1'b0;
        check_all("rst.emit1");
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_tri  = 0;
        m_cull = 0;
        m_err  = 0;
        chk("rst.valid_now", TW'(tvalid), '0);
        chk("rst.ready_now", TW'(ready), TW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all("rst.after");

        // Cull counter saturation, then clear beating a same-cycle increment.
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 65536; i++) model_step();
        repeat (65536) @(posedge clk);
        @(negedge clk);
        check_all("sat.full");
        chk("sat.value", TW'(cull_cnt), TW'(16'hFFFF));
        tick();
        check_all("sat.hold");
        drive(1'b1, 2'd0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        check_all("sat.clear");
        chk("sat.zero", TW'(cull_cnt), '0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_data();
            drive(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
            tick();
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
